// File: rtl/pipe_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type and the divide-by-zero
//               LO constant.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_mdu_pkg;

    // Operation encodings carried on the 3-bit op port
    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // LO value written on divide by zero: all ones in the low w bits.
    // Returned 64 bits wide; callers slice to their own WIDTH.
    function automatic logic [63:0] mdu_dz_lo(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mdu_signfix.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu_signfix
// Description : Combinational sign correction of the raw unsigned MDU result.
//               Multiply: product negated when the operand signs differ.
//               Divide  : quotient negated when the operand signs differ,
//                         remainder takes the dividend's sign; divide by
//                         zero forces LO to all ones.
// Ports       : i_raw      raw {upper,lower} result (2*WIDTH)
//               i_sign_a   sign of a (0 for unsigned ops)
//               i_sign_b   sign of b (0 for unsigned ops)
//               i_op       operation in flight
//               i_div_zero divisor was zero
//               o_hi/o_lo  corrected HI/LO values
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu_signfix
    import pipe_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_raw,
    input  logic               i_sign_a,
    input  logic               i_sign_b,
    input  logic [2:0]         i_op,
    input  logic               i_div_zero,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    localparam logic [63:0] c_DZ_FULL = mdu_dz_lo(WIDTH);

    logic               w_is_div;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_div = (i_op == MDU_DIV) || (i_op == MDU_DIVU);
    assign w_neg    = i_sign_a ^ i_sign_b;
    assign w_prod   = w_neg ? (~i_raw + 1'b1) : i_raw;
    assign w_quot   = w_neg ? (~i_raw[WIDTH-1:0] + 1'b1) : i_raw[WIDTH-1:0];
    // The remainder of |a| / 0 is |a|, so re-applying a's sign restores the
    // original dividend in HI as required for divide by zero.
    assign w_rem    = i_sign_a ? (~i_raw[2*WIDTH-1:WIDTH] + 1'b1)
                               : i_raw[2*WIDTH-1:WIDTH];

    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            o_hi = w_rem;
            o_lo = i_div_zero ? c_DZ_FULL[WIDTH-1:0] : w_quot;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_mdu.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mdu
// Description : Iterative multiply/divide unit with HI/LO registers, one
//               bit per cycle (shift-add multiply, restoring divide).
//               Optional macro PIPE_MDU_EARLY_OUT_EN: multiplies leave RUN
//               once the remaining multiplier bits are all zero.
// Ports       : clock, resetn (async active-low)
//               start/op/a/b  op issue from EXE
//               cancel        flush of the in-flight op
//               busy/done     status; hi/lo result registers
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu
    import pipe_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic                r_div_zero;
    logic [WIDTH-1:0]    r_opnd;     // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0]    r_mpl;      // remaining multiplier bits
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_done;

    logic                w_signed;
    logic                w_is_div;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic [WIDTH:0]      w_mul_sum;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [WIDTH:0]      w_rem_sh;
    logic [WIDTH:0]      w_diff;
    logic [2*WIDTH-1:0]  w_div_next;
    logic                w_early_exit;
    logic [2*WIDTH-1:0]  w_raw;
    logic [WIDTH-1:0]    w_fix_hi;
    logic [WIDTH-1:0]    w_fix_lo;

    assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_is_div = r_op[1];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add: add multiplicand into the upper half, shift right by one
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_mpl[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half
    // shifts the dividend out and the quotient bits in.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

`ifdef PIPE_MDU_EARLY_OUT_EN
    assign w_early_exit = !w_is_div && ((r_mpl >> 1) == '0);
    // After an early exit r_cnt holds the shifts that were skipped
    assign w_raw        = r_acc >> r_cnt;
`else
    assign w_early_exit = 1'b0;
    assign w_raw        = r_acc;
`endif

    pipe_mdu_signfix #(
        .WIDTH      (WIDTH)
    ) u_signfix (
        .i_raw      (w_raw),
        .i_sign_a   (r_sign_a),
        .i_sign_b   (r_sign_b),
        .i_op       (r_op),
        .i_div_zero (r_div_zero),
        .o_hi       (w_fix_hi),
        .o_lo       (w_fix_lo)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_mpl      <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            r_state    <= RUN;
                            r_cnt      <= CNT_W'(WIDTH);
                            r_op       <= op;
                            r_sign_a   <= w_signed & a[WIDTH-1];
                            r_sign_b   <= w_signed & b[WIDTH-1];
                            r_div_zero <= (b == '0);
                            if (op[1]) begin
                                r_opnd <= w_abs_b;
                                r_mpl  <= '0;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            end else begin
                                r_opnd <= w_abs_a;
                                r_mpl  <= w_abs_b;
                                r_acc  <= '0;
                            end
                        end else if (op == MDU_MTHI) begin
                            r_hi <= a;
                        end else if (op == MDU_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_is_div ? w_div_next : w_mul_next;
                        r_mpl <= r_mpl >> 1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1) || w_early_exit) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!cancel) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mdu
// Description : Directed self-checking bench for pipe_mdu (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mdu;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    pipe_mdu #(
        .WIDTH  (32)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one start cycle; returns #1 after the edge that samples it.
    task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b);
        @(negedge clock);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done; busy cycles include the cycle after the start edge.
    task automatic wait_done(output int n, output int bcyc);
        bit seen;
        seen = 0;
        n    = 0;
        bcyc = busy ? 1 : 0;
        while (n < 100 && !seen) begin
            @(posedge clock);
            #1;
            n++;
            if (done) seen = 1;
            else if (busy) bcyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: no done pulse within %0d edges", n);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        #2;
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_multu;
        int n, bc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bc);
        checks++; if (n !== 33)  begin errors++; $display("FAIL multu_latency: got %0d want 33", n); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_mult;
        int n, bc;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(n, bc);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_div;
        int n, bc;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", n); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL divu0_latency: got %0d want 33", n); end
        checks++; if (hi !== 32'd5)         begin errors++; $display("FAIL divu0_hi: got %h want 00000005", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        checks++; if (hi !== 32'h0)         begin errors++; $display("FAIL divmin_hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo: got %h want 80000000", lo); end
        issue(OP_DIV, 32'hFFFF_FFF6, 32'd0);
        wait_done(n, bc);
        checks++; if (hi !== 32'hFFFF_FFF6) begin errors++; $display("FAIL div0neg_hi: got %h want fffffff6", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0neg_lo: got %h want ffffffff", lo); end
    endtask

    task automatic test_mthi_mtlo;
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        issue(OP_MTLO, 32'h9, 32'h0);
        checks++; if (lo !== 32'h9)         begin errors++; $display("FAIL mtlo_lo: got %h want 00000009", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mtlo_status: got busy=%b done=%b want 0 0", busy, done);
        end
        issue(3'b110, 32'hDEAD_BEEF, 32'h1);
        issue(3'b111, 32'hDEAD_BEEF, 32'h1);
        checks++; if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9) begin
            errors++; $display("FAIL noop_ops: got busy=%b hi=%h lo=%h want 0 12345678 00000009", busy, hi, lo);
        end
    endtask

    task automatic test_busy_start;
        int n, bc;
        // hi=12345678, lo=9 on entry
        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_MTHI, 32'hDEAD_0000, 32'h0);
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL busy_mthi_ignored: got %h want 12345678", hi); end
        issue(OP_MULTU, 32'd3, 32'd3);
        wait_done(n, bc);
        checks++; if (n + 2 !== 33) begin errors++; $display("FAIL busy_latency: got %0d want 33", n + 2); end
        checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL busy_div_hi: got %h want 00000002", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_div_lo: got %h want 0000000e", lo); end
    endtask

    task automatic test_cancel;
        bit saw_done;
        // hi=2, lo=14 on entry
        issue(OP_MULTU, 32'd3, 32'hFFFF_FFFF);
        repeat (9) @(posedge clock);
        @(negedge clock);
        cancel = 1'b1;
        @(posedge clock); #1;
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
        saw_done = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (done) saw_done = 1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL cancel_no_done: got %b want 0", saw_done); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL cancel_hilo: got %h %h want 00000002 0000000e", hi, lo);
        end
        // cancel in IDLE suppresses a same-cycle start
        @(negedge clock);
        op = OP_MTHI; a = 32'hBAD0_0001; start = 1'b1; cancel = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL cancel_idle_mthi: got %h want 00000002", hi); end
        @(negedge clock);
        op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_div: busy got %b want 0", busy); end
    endtask

    task automatic test_early;
        int n, bc;
        issue(OP_MULTU, 32'h0000_1234, 32'd1);
        wait_done(n, bc);
`ifdef PIPE_MDU_EARLY_OUT_EN
        checks++; if (n > 3) begin errors++; $display("FAIL early_latency: got %0d want <=3", n); end
`else
        checks++; if (n !== 33) begin errors++; $display("FAIL full_latency: got %0d want 33", n); end
`endif
        checks++; if (lo !== 32'h0000_1234 || hi !== 32'h0) begin
            errors++; $display("FAIL mul_by_one: got %h %h want 00000000 00001234", hi, lo);
        end
        issue(OP_MULT, 32'hFFFF_FFF9, 32'd6);
        wait_done(n, bc);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
            errors++; $display("FAIL mult_small: got %h %h want ffffffff ffffffd6", hi, lo);
        end
    endtask

    task automatic test_reset_midrun;
        bit bad;
        issue(OP_MTHI, 32'hAAAA_AAAA, 32'h0);
        issue(OP_MTLO, 32'h5555_5555, 32'h0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL midreset_hilo: got %h %h want 0 0", hi, lo);
        end
        @(negedge clock);
        resetn = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy || hi !== 32'h0 || lo !== 32'h0) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL postreset_idle: got activity=%b want 0", bad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_busy_start();
        test_cancel();
        test_early();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
